// File: rtl/la_iocfgctrl_if.sv
// Request/response bus between a core-side register master and la_iocfgctrl.
// The request is a valid/ready handshake; the response is a 1-deep valid/ready return.
interface la_iocfgctrl_if #(
    parameter int CFGW = 1
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [7:0]        req_addr;
    logic [CFGW+1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic [CFGW+2:0]   rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/la_iocfgctrl.sv
// Per-pin {oe,ie,cfg} shadow registers with a power-up sequencer gating ie then oe to one padring side.
// Define LA_IOCFG_SYNC_EN to pass zp through a 2-flop synchronizer before it is sampled by reads.
//
// state  | meaning
// OFF    | pads safe, ie=oe=0
// IEWAIT | waiting ENDLY cycles before releasing ie
// OEWAIT | ie released, waiting ENDLY cycles before releasing oe
// ON     | ie and oe follow shadow values, pads_on=1
module la_iocfgctrl #(
    parameter int NPINS = 8,
    parameter int CFGW  = 1,
    parameter int ENDLY = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   pads_on,
    la_iocfgctrl_if.slave          bus,
    input  logic [NPINS-1:0]       zp,
    output logic [NPINS-1:0]       ie,
    output logic [NPINS-1:0]       oe,
    output logic [NPINS*CFGW-1:0]  cfg
);
    localparam int CW = $clog2(ENDLY + 1);

    localparam logic [1:0] OFF    = 2'd0;
    localparam logic [1:0] IEWAIT = 2'd1;
    localparam logic [1:0] OEWAIT = 2'd2;
    localparam logic [1:0] ON     = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [NPINS-1:0]      ie_sh;
    logic [NPINS-1:0]      oe_sh;
    logic [NPINS*CFGW-1:0] cfg_sh;
    logic [NPINS-1:0]      zp_s;

    logic                  accept;
    logic                  in_range;
    logic                  sel_ie;
    logic                  sel_oe;
    logic                  sel_zp;
    logic [CFGW-1:0]       sel_cfg;
    logic [NPINS-1:0]      gate_ie;
    logic [NPINS-1:0]      gate_oe;

`ifdef LA_IOCFG_SYNC_EN
    logic [NPINS-1:0] zp_meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zp_meta <= '0;
            zp_s    <= '0;
        end else begin
            zp_meta <= zp;
            zp_s    <= zp_meta;
        end
    end
`else
    assign zp_s = zp;
`endif

    assign bus.req_ready = !bus.rsp_valid | bus.rsp_ready;
    assign accept        = bus.req_valid & bus.req_ready;
    assign in_range      = {1'b0, bus.req_addr} < 9'(NPINS);
    assign pads_on       = (state == ON);
    assign cfg           = cfg_sh;

    always_comb begin
        sel_ie  = 1'b0;
        sel_oe  = 1'b0;
        sel_zp  = 1'b0;
        sel_cfg = '0;
        for (int p = 0; p < NPINS; p++) begin
            if (bus.req_addr == 8'(p)) begin
                sel_ie  = ie_sh[p];
                sel_oe  = oe_sh[p];
                sel_zp  = zp_s[p];
                sel_cfg = cfg_sh[p*CFGW +: CFGW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_sh  <= '0;
            oe_sh  <= '0;
            cfg_sh <= '0;
        end else if (accept && in_range && bus.req_write) begin
            for (int p = 0; p < NPINS; p++) begin
                if (bus.req_addr == 8'(p)) begin
                    oe_sh[p]                 <= bus.req_wdata[CFGW+1];
                    ie_sh[p]                 <= bus.req_wdata[CFGW];
                    cfg_sh[p*CFGW +: CFGW]   <= bus.req_wdata[CFGW-1:0];
                end
            end
        end
    end

    // Response holds its data until consumed; a new accept may overwrite it on the consuming edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= !in_range;
            if (!in_range)
                bus.rsp_rdata <= '0;
            else if (bus.req_write)
                bus.rsp_rdata <= {sel_zp, bus.req_wdata};
            else
                bus.rsp_rdata <= {sel_zp, sel_oe, sel_ie, sel_cfg};
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OFF;
            cnt   <= '0;
        end else begin
            case (state)
                OFF: begin
                    cnt <= '0;
                    if (enable)
                        state <= IEWAIT;
                end
                IEWAIT: begin
                    if (!enable) begin
                        state <= OFF;
                        cnt   <= '0;
                    end else if (cnt == CW'(ENDLY - 1)) begin
                        state <= OEWAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OEWAIT: begin
                    if (!enable) begin
                        state <= OFF;
                        cnt   <= '0;
                    end else if (cnt == CW'(ENDLY - 1)) begin
                        state <= ON;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                    if (!enable)
                        state <= OFF;
                end
            endcase
        end
    end

    always_comb begin
        gate_ie = '0;
        gate_oe = '0;
        if (state == OEWAIT || state == ON)
            gate_ie = ie_sh;
        if (state == ON)
            gate_oe = oe_sh;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie <= '0;
            oe <= '0;
        end else begin
            ie <= gate_ie;
            oe <= gate_oe;
        end
    end
endmodule

// File: tb/tb_la_iocfgctrl.sv
// Directed-vector bench for la_iocfgctrl: register access, sequencer timing, gating and zp sampling.
module tb_la_iocfgctrl;
    localparam int NPINS = 8;
    localparam int CFGW  = 1;
    localparam int ENDLY = 16;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              pads_on;
    logic [NPINS-1:0]  zp;
    logic [NPINS-1:0]  ie;
    logic [NPINS-1:0]  oe;
    logic [NPINS*CFGW-1:0] cfg;

    int n_cmp = 0;
    int n_err = 0;

    la_iocfgctrl_if #(.CFGW(CFGW)) bus ();

    la_iocfgctrl #(.NPINS(NPINS), .CFGW(CFGW), .ENDLY(ENDLY)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .pads_on (pads_on),
        .bus     (bus),
        .zp      (zp),
        .ie      (ie),
        .oe      (oe),
        .cfg     (cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One request with rsp_ready=1; returns the response captured just after the accept edge.
    task automatic xact(input logic w, input logic [7:0] a, input logic [CFGW+1:0] d,
                        output logic [CFGW+2:0] rd, output logic er);
        int n;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (n >= 20) check_val("req_ready_timeout", 32'd0, 32'd1);
        tick(1);
        bus.req_valid = 1'b0;
        check_val("xact_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
    endtask

    logic [CFGW+2:0] rd;
    logic            er;
    logic [CFGW+2:0] exp_zp0;
    int              nrsp;

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        zp            = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);

        check_val("rst_ie", 32'(ie), 32'h0);
        check_val("rst_oe", 32'(oe), 32'h0);
        check_val("rst_cfg", 32'(cfg), 32'h0);
        check_val("rst_pads_on", 32'(pads_on), 32'h0);
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_val("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);

        // Write pin3 {oe=1,ie=1,cfg=1}; cfg goes out straight away even with the sequencer OFF.
        xact(1'b1, 8'd3, 3'b111, rd, er);
        check_val("wr3_rdata", 32'(rd), 32'h7);
        check_val("wr3_err", 32'(er), 32'h0);
        check_val("wr3_cfg", 32'(cfg), 32'h08);
        check_val("wr3_ie_off", 32'(ie), 32'h0);

        // Power-up: edge 0 samples enable; ie at edge 17, ON at edge 32, oe at edge 33.
        enable = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            tick(1);
            if (k == 16) check_val("seq_ie_e16", 32'(ie), 32'h00);
            if (k == 17) check_val("seq_ie_e17", 32'(ie), 32'h08);
            if (k == 31) check_val("seq_pads_e31", 32'(pads_on), 32'h0);
            if (k == 32) check_val("seq_pads_e32", 32'(pads_on), 32'h1);
            if (k == 32) check_val("seq_oe_e32", 32'(oe), 32'h00);
            if (k == 33) check_val("seq_oe_e33", 32'(oe), 32'h08);
        end

        // Shadow write in ON lands on ie one edge after the accept edge.
        xact(1'b1, 8'd1, 3'b010, rd, er);
        check_val("on_wr1_ie_now", 32'(ie), 32'h08);
        tick(1);
        check_val("on_wr1_ie_next", 32'(ie), 32'h0A);
        check_val("on_wr1_oe_next", 32'(oe), 32'h08);

        // Drop enable: OFF next edge, outputs cleared one edge later, cfg untouched.
        enable = 1'b0;
        tick(1);
        check_val("drop_pads_on", 32'(pads_on), 32'h0);
        check_val("drop_ie_hold", 32'(ie), 32'h0A);
        tick(1);
        check_val("drop_ie", 32'(ie), 32'h00);
        check_val("drop_oe", 32'(oe), 32'h00);
        check_val("drop_cfg", 32'(cfg), 32'h08);

        // Out-of-range access.
        zp = 8'h08;
        xact(1'b0, 8'(NPINS), 3'b000, rd, er);
        check_val("oor_rd_err", 32'(er), 32'h1);
        check_val("oor_rd_rdata", 32'(rd), 32'h0);
        xact(1'b1, 8'd200, 3'b111, rd, er);
        check_val("oor_wr_err", 32'(er), 32'h1);
        check_val("oor_wr_cfg", 32'(cfg), 32'h08);
        xact(1'b0, 8'd3, 3'b000, rd, er);
        check_val("rd3_rdata", 32'(rd), 32'hF);
        check_val("rd3_err", 32'(er), 32'h0);

        // Back-pressure: response held while rsp_ready=0.
        tick(1);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd1;
        tick(1);
        bus.req_addr  = 8'd3;
        for (int i = 0; i < 5; i++) begin
            check_val("stall_req_ready", 32'(bus.req_ready), 32'h0);
            check_val("stall_rdata", 32'(bus.rsp_rdata), 32'h2);
            tick(1);
        end
        bus.rsp_ready = 1'b1;
        nrsp = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (bus.rsp_valid) nrsp++;
            check_val("b2b_rdata", 32'(bus.rsp_rdata), (i % 2 == 0) ? 32'hF : 32'h2);
            bus.req_addr = (i % 2 == 0) ? 8'd1 : 8'd3;
        end
        bus.req_valid = 1'b0;
        check_val("b2b_count", 32'(nrsp), 32'd4);
        tick(1);
        check_val("b2b_drain", 32'(bus.rsp_valid), 32'h0);

        // zp step on pin0, read accepted one cycle later.
        zp = 8'h09;
        tick(1);
`ifdef LA_IOCFG_SYNC_EN
        exp_zp0 = 4'h0;
`else
        exp_zp0 = 4'h8;
`endif
        xact(1'b0, 8'd0, 3'b000, rd, er);
        check_val("zp0_rdata", 32'(rd), 32'(exp_zp0));

        // Asynchronous reset while ON with a response pending.
        enable = 1'b1;
        tick(40);
        check_val("pre_rst_pads_on", 32'(pads_on), 32'h1);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'd3;
        tick(1);
        bus.req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_ie", 32'(ie), 32'h0);
        check_val("arst_oe", 32'(oe), 32'h0);
        check_val("arst_cfg", 32'(cfg), 32'h0);
        check_val("arst_pads_on", 32'(pads_on), 32'h0);
        check_val("arst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        tick(1);
        reset = 1'b0;
        tick(3);
        check_val("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_val("post_rst_ie", 32'(ie), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
